// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: turns PS/2 set-2 byte stream into key events buffered in a FIFO
module ps2_scancode_decoder #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [7:0] data_i,
   input  logic       valid_i,
   output logic [7:0] key_code_o,
   output logic       extended_o,
   output logic       break_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic       overflow_o
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
   state_t         state_q, state_d;
   logic           emit, is_ctrl, in_ext, in_brk, pop, full, do_push;
   logic [9:0]     mem_q [FIFO_DEPTH];
   logic [AW-1:0]  rd_q, wr_q;
   logic [CW-1:0]  cnt_q;
   logic           ovf_q;
   // prefix decoding: E0/F0 accumulate, control bytes abort, anything else emits
   always_comb begin
      is_ctrl = data_i inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'hE1};
      in_ext  = (state_q == EXT) || (state_q == EXT_BRK);
      in_brk  = (state_q == BRK) || (state_q == EXT_BRK);
      state_d = state_q;
      emit    = 1'b0;
      if (valid_i) begin
         if (is_ctrl)
            state_d = IDLE;
         else if (data_i == 8'hE0)
            state_d = in_brk ? EXT_BRK : EXT;
         else if (data_i == 8'hF0)
            state_d = in_ext ? EXT_BRK : BRK;
         else begin
            state_d = IDLE;
            emit    = 1'b1;
         end
      end
   end
   // decoder state register
   always_ff @(posedge clk_i) begin
      state_q <= reset_i ? IDLE : state_d;
   end
   assign valid_o = cnt_q != '0;
   assign full    = cnt_q == CW'(FIFO_DEPTH);
   assign pop     = valid_o && ready_i;
   assign do_push = emit && (!full || pop);
   // FIFO bookkeeping; a push into a full FIFO without a pop is dropped and latched as overflow
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         rd_q  <= pop ? rd_q + 1'b1 : rd_q;
         wr_q  <= do_push ? wr_q + 1'b1 : wr_q;
         cnt_q <= cnt_q + CW'(do_push) - CW'(pop);
         ovf_q <= ovf_q || (emit && full && !pop);
      end
   end
   // event storage, no reset needed since the head is masked while empty
   always_ff @(posedge clk_i) begin
      if (do_push && !reset_i)
         mem_q[wr_q] <= {in_ext, in_brk, data_i};
   end
   assign {extended_o, break_o, key_code_o} = valid_o ? mem_q[rd_q] : 10'h000;
   assign overflow_o = ovf_q;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: randomized + directed scoreboard bench for ps2_scancode_decoder
module tb_ps2_scancode_decoder;
   localparam int DEPTH = 8;
   logic       clk_i = 1'b0, reset_i = 1'b1, valid_i = 1'b0, ready_i = 1'b0;
   logic [7:0] data_i = 8'h00;
   logic [7:0] key_code_o;
   logic       extended_o, break_o, valid_o, overflow_o;
   int         vectors = 0, fails = 0;
   logic [9:0] exp_q [$];
   logic       pend_ext = 1'b0, pend_brk = 1'b0, exp_ovf = 1'b0, rst_last = 1'b0;

   ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i),
      .key_code_o(key_code_o), .extended_o(extended_o), .break_o(break_o),
      .valid_o(valid_o), .ready_i(ready_i), .overflow_o(overflow_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic ctrl_byte(input logic [7:0] b);
      logic [7:0] list [9] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'hE1};
      foreach (list[i]) if (list[i] == b) return 1'b1;
      return 1'b0;
   endfunction

   // reference model: prefix flags plus a bounded event list; the monitor removes
   // the head before the edge that pops it, so a push fits whenever size < DEPTH
   always @(posedge clk_i) begin
      rst_last = reset_i;
      if (reset_i) begin
         exp_q.delete();
         pend_ext = 1'b0;
         pend_brk = 1'b0;
         exp_ovf  = 1'b0;
      end else if (valid_i) begin
         if (ctrl_byte(data_i)) begin
            pend_ext = 1'b0;
            pend_brk = 1'b0;
         end else if (data_i == 8'hE0) pend_ext = 1'b1;
         else if (data_i == 8'hF0) pend_brk = 1'b1;
         else begin
            if (exp_q.size() < DEPTH) exp_q.push_back({pend_ext, pend_brk, data_i});
            else exp_ovf = 1'b1;
            pend_ext = 1'b0;
            pend_brk = 1'b0;
         end
      end
   end

   // monitor: compares presented head, validity, overflow and reset values
   always @(negedge clk_i) begin
      vectors++;
      if (valid_o !== (exp_q.size() != 0)) begin
         fails++;
         $display("FAIL valid_o: got %b expected %b", valid_o, exp_q.size() != 0);
      end
      if (valid_o === 1'b1 && exp_q.size() != 0) begin
         vectors++;
         if ({extended_o, break_o, key_code_o} !== exp_q[0]) begin
            fails++;
            $display("FAIL event: got code=%h ext=%b brk=%b expected code=%h ext=%b brk=%b",
                     key_code_o, extended_o, break_o, exp_q[0][7:0], exp_q[0][9], exp_q[0][8]);
         end
         if (ready_i) void'(exp_q.pop_front());
      end
      vectors++;
      if (overflow_o !== exp_ovf) begin
         fails++;
         $display("FAIL overflow_o: got %b expected %b", overflow_o, exp_ovf);
      end
      if (rst_last) begin
         vectors++;
         if ({key_code_o, extended_o, break_o, valid_o, overflow_o} !== 12'h000) begin
            fails++;
            $display("FAIL reset_outputs: got code=%h ext=%b brk=%b v=%b ovf=%b expected all zero",
                     key_code_o, extended_o, break_o, valid_o, overflow_o);
         end
      end
   end

   task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic rs);
      @(posedge clk_i);
      #1;
      valid_i = v;
      data_i  = d;
      ready_i = r;
      reset_i = rs;
   endtask

   task automatic idle(input int n, input logic r);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, r, 1'b0);
   endtask

   initial begin
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      cyc(1'b0, 8'h00, 1'b1, 1'b1);
      idle(2, 1'b1);
      // make then break of 1C
      cyc(1'b1, 8'h1C, 1'b1, 1'b0);
      idle(1, 1'b1);
      cyc(1'b1, 8'hF0, 1'b1, 1'b0);
      cyc(1'b1, 8'h1C, 1'b1, 1'b0);
      idle(3, 1'b1);
      // extended make and break
      cyc(1'b1, 8'hE0, 1'b1, 1'b0);
      cyc(1'b1, 8'h75, 1'b1, 1'b0);
      cyc(1'b1, 8'hE0, 1'b1, 1'b0);
      cyc(1'b1, 8'hF0, 1'b1, 1'b0);
      cyc(1'b1, 8'h75, 1'b1, 1'b0);
      idle(3, 1'b1);
      // control byte clears a pending prefix
      cyc(1'b1, 8'hE0, 1'b1, 1'b0);
      cyc(1'b1, 8'hFA, 1'b1, 1'b0);
      cyc(1'b1, 8'h1C, 1'b1, 1'b0);
      idle(3, 1'b1);
      // overflow with a stalled consumer, then drain
      for (int i = 1; i <= 9; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
      idle(2, 1'b0);
      idle(12, 1'b1);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      idle(2, 1'b0);
      // full FIFO with simultaneous push and pop
      for (int i = 0; i < 8; i++) cyc(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0);
      idle(1, 1'b0);
      cyc(1'b1, 8'h2A, 1'b1, 1'b0);
      idle(12, 1'b1);
      // reset in the middle of an E0 F0 prefix
      cyc(1'b1, 8'hE0, 1'b1, 1'b0);
      cyc(1'b1, 8'hF0, 1'b1, 1'b0);
      cyc(1'b1, 8'h33, 1'b1, 1'b1);
      idle(1, 1'b1);
      cyc(1'b1, 8'h74, 1'b1, 1'b0);
      idle(3, 1'b1);
      // randomized traffic with varying consumer pressure and rare resets
      for (int i = 0; i < 3000; i++) begin
         automatic int pick = $urandom_range(0, 99);
         automatic logic [7:0] b = 8'($urandom_range(1, 255));
         automatic int rp = (i / 500) % 3 == 0 ? 25 : 75;
         if (pick < 20) b = 8'hE0;
         else if (pick < 35) b = 8'hF0;
         else if (pick < 45) begin
            logic [7:0] cl [9] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'hE1};
            b = cl[$urandom_range(0, 8)];
         end
         cyc($urandom_range(0, 1) == 1, b, $urandom_range(0, 99) < rp,
             $urandom_range(0, 599) == 0);
      end
      idle(20, 1'b1);
      @(posedge clk_i);
      #1;
      vectors++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL final_drain: %0d events left, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule
